// File: rtl/bus_pkg.sv
// Shared command/state encodings, request record and parameter defaults
// for the bus request agent and its request queue.
package bus_pkg;

  localparam int QDEPTH_DEF      = 4;
  localparam int GNT_TIMEOUT_DEF = 255;

  localparam logic [1:0] CMD_RD   = 2'b00;
  localparam logic [1:0] CMD_RDX  = 2'b01;
  localparam logic [1:0] CMD_WB   = 2'b10;
  localparam logic [1:0] CMD_UPGR = 2'b11;

  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_REQ  = 2'd1;
  localparam logic [1:0] P_OWN  = 2'd2;
  localparam logic [1:0] P_REL  = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_OWN  = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  cmd;
  } bus_req_t;

endpackage

// File: rtl/req_queue.sv
// FIFO of pending cache-controller requests. Pointers wrap modulo DEPTH;
// a push while full is dropped, a pop while empty is ignored.
module req_queue
  import bus_pkg::*;
#(
  parameter int DEPTH = QDEPTH_DEF
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  bus_req_t push_data,
  input  logic     pop,
  output bus_req_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  bus_req_t      mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bus_req_agent.sv
// Bus request agent: queues CPU requests and arbitrates them onto the shared
// bus (proc FSM with grant timeout), plus an independent snoop write-back FSM.
module bus_req_agent
  import bus_pkg::*;
#(
  parameter int QDEPTH      = QDEPTH_DEF,
  parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  input  logic [31:0] cpu_req_addr,
  input  logic [1:0]  cpu_req_cmd,
  output logic        cpu_req_ready,
  output logic        Com_Bus_Req_proc,
  input  logic        Com_Bus_Gnt_proc,
  output logic        Com_Bus_Req_snoop,
  input  logic        Com_Bus_Gnt_snoop,
  input  logic        snoop_wb_req,
  input  logic [31:0] snoop_wb_addr,
  output logic        snoop_wb_done,
  output logic        bus_valid,
  output logic [31:0] bus_addr,
  output logic [1:0]  bus_cmd,
  input  logic        bus_xfer_done,
  output logic        cpu_done,
  output logic        gnt_timeout
);

  localparam logic [7:0] WAIT_LAST = 8'(GNT_TIMEOUT - 1);

  logic [1:0] p_state, p_next;
  logic [1:0] s_state, s_next;
  logic [7:0] wait_cnt;
  bus_req_t   head;
  bus_req_t   enq_data;
  logic       q_full, q_empty;
  logic       enq, proc_done, snoop_done, timeout_hit;

  // Handshake: a request is accepted on any clk edge where cpu_req_valid and
  // cpu_req_ready are both high; ready depends only on queue occupancy.
  assign cpu_req_ready = !q_full;
  assign enq           = cpu_req_valid && cpu_req_ready;
  assign enq_data      = '{addr: cpu_req_addr, cmd: cpu_req_cmd};

  // When both FSMs own the bus the snoop path drives it and takes the done.
  assign snoop_done    = (s_state == S_OWN) && bus_xfer_done;
  assign proc_done     = (p_state == P_OWN) && bus_xfer_done && (s_state != S_OWN);
  assign cpu_done      = proc_done && !rst;
  assign snoop_wb_done = snoop_done && !rst;

  req_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (enq),
    .push_data (enq_data),
    .pop       (proc_done),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_comb begin
    p_next      = p_state;
    timeout_hit = 1'b0;
    case (p_state)
      P_IDLE: if (!q_empty) p_next = P_REQ;
      P_REQ: begin
        if (Com_Bus_Gnt_proc) begin
          p_next = P_OWN;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          p_next      = P_REL;
        end
      end
      P_OWN:   if (proc_done) p_next = P_REL;
      default: if (!Com_Bus_Gnt_proc) p_next = P_IDLE;
    endcase
  end

  always_comb begin
    s_next = s_state;
    case (s_state)
      S_IDLE:  if (snoop_wb_req) s_next = S_REQ;
      S_REQ:   if (Com_Bus_Gnt_snoop) s_next = S_OWN;
      S_OWN:   if (bus_xfer_done) s_next = S_REL;
      default: if (!Com_Bus_Gnt_snoop) s_next = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_state           <= P_IDLE;
      s_state           <= S_IDLE;
      wait_cnt          <= '0;
      gnt_timeout       <= 1'b0;
      Com_Bus_Req_proc  <= 1'b0;
      Com_Bus_Req_snoop <= 1'b0;
      bus_valid         <= 1'b0;
      bus_addr          <= '0;
      bus_cmd           <= '0;
    end else begin
      p_state           <= p_next;
      s_state           <= s_next;
      wait_cnt          <= ((p_state == P_REQ) && (p_next == P_REQ)) ? wait_cnt + 8'd1 : 8'd0;
      if (timeout_hit) gnt_timeout <= 1'b1;
      Com_Bus_Req_proc  <= (p_next == P_REQ) || (p_next == P_OWN);
      Com_Bus_Req_snoop <= (s_next == S_REQ) || (s_next == S_OWN);
      if (s_next == S_OWN) begin
        bus_valid <= 1'b1;
        bus_addr  <= snoop_wb_addr;
        bus_cmd   <= CMD_WB;
      end else if (p_next == P_OWN) begin
        bus_valid <= 1'b1;
        bus_addr  <= head.addr;
        bus_cmd   <= head.cmd;
      end else begin
        bus_valid <= 1'b0;
        bus_addr  <= '0;
        bus_cmd   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_req_agent.sv
// Bench for bus_req_agent: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_bus_req_agent;

  localparam int QD  = 4;
  localparam int TMO = 8;
  localparam int PH_IDLE = 0, PH_REQ = 1, PH_OWN = 2, PH_REL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid;
  logic [31:0] cpu_req_addr;
  logic [1:0]  cpu_req_cmd;
  logic        cpu_req_ready;
  logic        Com_Bus_Req_proc;
  logic        Com_Bus_Gnt_proc;
  logic        Com_Bus_Req_snoop;
  logic        Com_Bus_Gnt_snoop;
  logic        snoop_wb_req;
  logic [31:0] snoop_wb_addr;
  logic        snoop_wb_done;
  logic        bus_valid;
  logic [31:0] bus_addr;
  logic [1:0]  bus_cmd;
  logic        bus_xfer_done;
  logic        cpu_done;
  logic        gnt_timeout;

  bus_req_agent #(.QDEPTH(QD), .GNT_TIMEOUT(TMO)) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_req_valid     (cpu_req_valid),
    .cpu_req_addr      (cpu_req_addr),
    .cpu_req_cmd       (cpu_req_cmd),
    .cpu_req_ready     (cpu_req_ready),
    .Com_Bus_Req_proc  (Com_Bus_Req_proc),
    .Com_Bus_Gnt_proc  (Com_Bus_Gnt_proc),
    .Com_Bus_Req_snoop (Com_Bus_Req_snoop),
    .Com_Bus_Gnt_snoop (Com_Bus_Gnt_snoop),
    .snoop_wb_req      (snoop_wb_req),
    .snoop_wb_addr     (snoop_wb_addr),
    .snoop_wb_done     (snoop_wb_done),
    .bus_valid         (bus_valid),
    .bus_addr          (bus_addr),
    .bus_cmd           (bus_cmd),
    .bus_xfer_done     (bus_xfer_done),
    .cpu_done          (cpu_done),
    .gnt_timeout       (gnt_timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model state / scoreboard ----------------
  int           n_vec = 0;
  int           n_err = 0;
  logic [33:0]  exp_q[$];          // pending requests {addr, cmd}, head first
  int           p_ph = PH_IDLE;
  int           s_ph = PH_IDLE;
  int           p_req_cycles = 0;  // cycles the current proc request has been up
  bit           m_timeout = 1'b0;
  logic [31:0]  m_snoop_addr = '0;
  bit           model_valid = 1'b0;
  int           snoop_done_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit p_done, s_done, push;
    if (rst) begin
      exp_q.delete();
      p_ph = PH_IDLE;
      s_ph = PH_IDLE;
      p_req_cycles = 0;
      m_timeout = 1'b0;
      model_valid = 1'b1;
      return;
    end
    if (!model_valid) return;
    p_done = (p_ph == PH_OWN) && bus_xfer_done && (s_ph != PH_OWN);
    s_done = (s_ph == PH_OWN) && bus_xfer_done;
    push   = cpu_req_valid && (exp_q.size() < QD);
    case (p_ph)
      PH_IDLE: if (exp_q.size() != 0) begin p_ph = PH_REQ; p_req_cycles = 1; end
      PH_REQ: begin
        if (Com_Bus_Gnt_proc) p_ph = PH_OWN;
        else if (p_req_cycles >= TMO) begin m_timeout = 1'b1; p_ph = PH_REL; end
        else p_req_cycles++;
      end
      PH_OWN:  if (p_done) p_ph = PH_REL;
      default: if (!Com_Bus_Gnt_proc) p_ph = PH_IDLE;
    endcase
    case (s_ph)
      PH_IDLE: if (snoop_wb_req) s_ph = PH_REQ;
      PH_REQ:  if (Com_Bus_Gnt_snoop) s_ph = PH_OWN;
      PH_OWN:  if (s_done) s_ph = PH_REL;
      default: if (!Com_Bus_Gnt_snoop) s_ph = PH_IDLE;
    endcase
    if (p_done) void'(exp_q.pop_front());
    if (push) exp_q.push_back({cpu_req_addr, cpu_req_cmd});
    if (s_done) snoop_done_cnt++;
    if (s_ph == PH_OWN) m_snoop_addr = snoop_wb_addr;
  endtask

  task automatic compare_cycle();
    logic [33:0] hd;
    logic        ev;
    logic [31:0] ea;
    logic [1:0]  ec;
    ev = 1'b0; ea = '0; ec = '0; hd = '0;
    if (s_ph == PH_OWN) begin
      ev = 1'b1; ea = m_snoop_addr; ec = 2'b10;
    end else if (p_ph == PH_OWN && exp_q.size() > 0) begin
      hd = exp_q[0]; ev = 1'b1; ea = hd[33:2]; ec = hd[1:0];
    end
    check("cmp_ready", cpu_req_ready, exp_q.size() < QD);
    check("cmp_req_proc", Com_Bus_Req_proc, (p_ph == PH_REQ) || (p_ph == PH_OWN));
    check("cmp_req_snoop", Com_Bus_Req_snoop, (s_ph == PH_REQ) || (s_ph == PH_OWN));
    check("cmp_bus_valid", bus_valid, ev);
    if (ev) begin
      check("cmp_bus_addr", bus_addr, ea);
      check("cmp_bus_cmd", bus_cmd, ec);
    end
    check("cmp_gnt_timeout", gnt_timeout, m_timeout);
    check("cmp_cpu_done", cpu_done, !rst && p_ph == PH_OWN && bus_xfer_done && s_ph != PH_OWN);
    check("cmp_snoop_done", snoop_wb_done, !rst && s_ph == PH_OWN && bus_xfer_done);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (model_valid) compare_cycle();
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic serve_one(input logic [31:0] ea, input logic [1:0] ec);
    int k;
    Com_Bus_Gnt_proc = 1'b1;
    k = 0;
    while (bus_valid !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check("serve_wait_bound", k < 40, 1);
    check("serve_addr", bus_addr, ea);
    check("serve_cmd", bus_cmd, ec);
    bus_xfer_done = 1'b1;
    #1;
    check("serve_cpu_done", cpu_done, 1);
    tick();
    bus_xfer_done = 1'b0;
    Com_Bus_Gnt_proc = 1'b0;
    check("serve_rel_req_low", Com_Bus_Req_proc, 0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int low;
    int k;
    int snoop_start;
    bit snoop_on;
    rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_cmd = '0;
    Com_Bus_Gnt_proc = 1'b0; Com_Bus_Gnt_snoop = 1'b0;
    snoop_wb_req = 1'b0; snoop_wb_addr = '0; bus_xfer_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", cpu_req_ready, 1);
    check("rst_req_proc", Com_Bus_Req_proc, 0);
    check("rst_req_snoop", Com_Bus_Req_snoop, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_gnt_timeout", gnt_timeout, 0);

    // single read with grant two cycles into the request
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h1000; cpu_req_cmd = 2'b00;
    tick();
    cpu_req_valid = 1'b0;
    tick();
    check("rd_req_raised", Com_Bus_Req_proc, 1);
    tick();
    Com_Bus_Gnt_proc = 1'b1;
    tick();
    check("rd_bus_valid", bus_valid, 1);
    check("rd_bus_addr", bus_addr, 32'h1000);
    check("rd_bus_cmd", bus_cmd, 2'b00);
    bus_xfer_done = 1'b1;
    #1;
    check("rd_cpu_done", cpu_done, 1);
    tick();
    bus_xfer_done = 1'b0;
    #1;
    check("rd_done_is_pulse", cpu_done, 0);
    check("rd_rel_req_low", Com_Bus_Req_proc, 0);
    check("rd_rel_bus_idle", bus_valid, 0);
    tick();
    check("rd_rel_held_by_gnt", Com_Bus_Req_proc, 0);
    Com_Bus_Gnt_proc = 1'b0;
    tick(); tick();
    check("rd_idle_no_req", Com_Bus_Req_proc, 0);

    // fill the queue, offer a fifth, then drain in order
    for (int i = 0; i < 4; i++) begin
      cpu_req_valid = 1'b1; cpu_req_addr = 32'h100 * (i + 1); cpu_req_cmd = 2'(i);
      tick();
    end
    cpu_req_addr = 32'hDEAD; cpu_req_cmd = 2'b11;
    #1;
    check("full_not_ready", cpu_req_ready, 0);
    tick();
    cpu_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) serve_one(32'h100 * (i + 1), 2'(i));
    tick(); tick();
    check("fifth_refused", Com_Bus_Req_proc, 0);
    check("drained_ready", cpu_req_ready, 1);

    // snoop write-back while proc waits for a grant
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h2000; cpu_req_cmd = 2'b01;
    tick();
    cpu_req_valid = 1'b0;
    tick();
    snoop_wb_req = 1'b1; snoop_wb_addr = 32'h3000;
    tick();
    check("snp_req", Com_Bus_Req_snoop, 1);
    check("snp_proc_waiting", Com_Bus_Req_proc, 1);
    Com_Bus_Gnt_snoop = 1'b1;
    tick();
    check("snp_bus_valid", bus_valid, 1);
    check("snp_bus_addr", bus_addr, 32'h3000);
    check("snp_bus_cmd", bus_cmd, 2'b10);
    bus_xfer_done = 1'b1;
    #1;
    check("snp_wb_done", snoop_wb_done, 1);
    check("snp_no_cpu_done", cpu_done, 0);
    tick();
    bus_xfer_done = 1'b0; snoop_wb_req = 1'b0; Com_Bus_Gnt_snoop = 1'b0;
    check("snp_req_dropped", Com_Bus_Req_snoop, 0);
    check("snp_proc_still_pending", Com_Bus_Req_proc, 1);
    serve_one(32'h2000, 2'b01);
    check("snp_no_timeout", gnt_timeout, 0);

    // grant timeout then retry of the same head
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h4000; cpu_req_cmd = 2'b00;
    tick();
    cpu_req_valid = 1'b0;
    tick();
    for (int i = 0; i < TMO; i++) begin
      check("tmo_req_high", Com_Bus_Req_proc, 1);
      check("tmo_flag_low", gnt_timeout, 0);
      tick();
    end
    check("tmo_flag_set", gnt_timeout, 1);
    check("tmo_req_dropped", Com_Bus_Req_proc, 0);
    low = 0;
    while (Com_Bus_Req_proc !== 1'b1 && low < 10) begin
      low++;
      tick();
    end
    check("tmo_reraise_bound", (low >= 1) && (low < 10), 1);
    check("tmo_sticky", gnt_timeout, 1);
    serve_one(32'h4000, 2'b00);
    check("tmo_sticky_after_serve", gnt_timeout, 1);

    // reset while owning the bus
    cpu_req_valid = 1'b1; cpu_req_addr = 32'h5000; cpu_req_cmd = 2'b00;
    tick();
    cpu_req_addr = 32'h6000; cpu_req_cmd = 2'b10;
    tick();
    cpu_req_valid = 1'b0;
    Com_Bus_Gnt_proc = 1'b1;
    k = 0;
    while (bus_valid !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    check("own_before_rst", bus_addr, 32'h5000);
    rst = 1'b1; bus_xfer_done = 1'b1;
    #1;
    check("rst_no_cpu_done", cpu_done, 0);
    check("rst_no_snoop_done", snoop_wb_done, 0);
    tick();
    rst = 1'b0; bus_xfer_done = 1'b0; Com_Bus_Gnt_proc = 1'b0;
    check("rst_own_bus_valid", bus_valid, 0);
    check("rst_own_bus_addr", bus_addr, 0);
    check("rst_own_bus_cmd", bus_cmd, 0);
    check("rst_own_req_proc", Com_Bus_Req_proc, 0);
    check("rst_own_timeout_cleared", gnt_timeout, 0);
    check("rst_own_ready", cpu_req_ready, 1);
    tick(); tick();
    check("rst_queue_empty", Com_Bus_Req_proc, 0);

    // randomized traffic
    snoop_on = 1'b0;
    snoop_start = 0;
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 599) == 0);
      cpu_req_valid = $urandom_range(0, 1) == 1;
      cpu_req_addr  = $urandom;
      cpu_req_cmd   = 2'($urandom_range(0, 3));
      if (p_ph == PH_REQ)      Com_Bus_Gnt_proc = ($urandom_range(0, 5) == 0);
      else if (p_ph == PH_REL) Com_Bus_Gnt_proc = ($urandom_range(0, 1) == 0);
      else                     Com_Bus_Gnt_proc = ($urandom_range(0, 7) == 0);
      if (s_ph == PH_REQ || s_ph == PH_REL) Com_Bus_Gnt_snoop = ($urandom_range(0, 2) == 0);
      else                                  Com_Bus_Gnt_snoop = ($urandom_range(0, 7) == 0);
      bus_xfer_done = ($urandom_range(0, 2) == 0);
      if (snoop_on && snoop_done_cnt != snoop_start) snoop_on = 1'b0;
      if (!snoop_on && $urandom_range(0, 15) == 0) begin
        snoop_on      = 1'b1;
        snoop_start   = snoop_done_cnt;
        snoop_wb_addr = $urandom;
      end
      snoop_wb_req = snoop_on;
      tick();
    end

    rst = 1'b0; cpu_req_valid = 1'b0; Com_Bus_Gnt_proc = 1'b0;
    Com_Bus_Gnt_snoop = 1'b0; snoop_wb_req = 1'b0; bus_xfer_done = 1'b0;
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
